// File: rtl/sfifo_wl.sv
// Single-clock FIFO with standard or first-word-fall-through read, almost thresholds and a water level.
// Define SFIFO_ERR_FLAG_EN to add err_clr plus sticky overflow/underflow flags.
module sfifo_wl #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 8,
    parameter int FWFT             = 0,
    parameter int PROG_THRESH      = 0,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SFIFO_ERR_FLAG_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty,
    input  logic [DEPTH_WIDTH:0]  af_thresh,
    input  logic [DEPTH_WIDTH:0]  ae_thresh,
    output logic [DEPTH_WIDTH:0]  water_level
);
    localparam int CAP = 1 << DEPTH_WIDTH;
    localparam int LW  = DEPTH_WIDTH + 1;

    logic [DATA_WIDTH-1:0]  r_mem [CAP];
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_wr_full;
    logic                   r_almost_full;
    logic                   r_rd_empty;
    logic                   r_almost_empty;
    logic [DATA_WIDTH-1:0]  r_rd_data;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_out_vld;
    logic                   w_load;
    logic                   w_empty_nxt;
    logic [LW-1:0]          w_level_nxt;
    logic [LW-1:0]          w_mem_cnt;
    logic [31:0]            w_af_th;
    logic [31:0]            w_ae_th;
    logic [31:0]            w_lvl32;

    assign w_wr_acc  = wr_en & ~r_wr_full & ~rst;
    assign w_rd_acc  = rd_en & ~r_rd_empty;
    assign w_out_vld = ~r_rd_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // In FWFT mode the prefetch word is part of r_level; it is valid exactly while rd_empty is low,
    // and it is refilled from memory whenever it is empty or being popped.
    always_comb begin
        w_mem_cnt   = r_level;
        w_load      = w_rd_acc;
        w_empty_nxt = (w_level_nxt == '0);
        if (FWFT != 0) begin
            w_mem_cnt   = r_level - LW'(w_out_vld);
            w_load      = (w_mem_cnt != '0) && (r_rd_empty || w_rd_acc);
            w_empty_nxt = ~w_load & (r_rd_empty | w_rd_acc);
        end
    end

    assign w_af_th = (PROG_THRESH != 0) ? 32'(af_thresh) : 32'(ALMOST_FULL_NUM);
    assign w_ae_th = (PROG_THRESH != 0) ? 32'(ae_thresh) : 32'(ALMOST_EMPTY_NUM);
    assign w_lvl32 = 32'(w_level_nxt);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_wr_full      <= 1'b0;
            r_rd_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (w_af_th == 32'd0);
            r_rd_data      <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
            end
            if (w_load) begin
                r_rd_ptr  <= r_rd_ptr + DEPTH_WIDTH'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_level        <= w_level_nxt;
            r_wr_full      <= (w_level_nxt == LW'(CAP));
            r_almost_full  <= (w_lvl32 >= w_af_th);
            r_almost_empty <= (w_lvl32 <= w_ae_th);
            r_rd_empty     <= w_empty_nxt;
        end
    end

    assign wr_full      = r_wr_full;
    assign almost_full  = r_almost_full;
    assign rd_data      = r_rd_data;
    assign rd_empty     = r_rd_empty;
    assign almost_empty = r_almost_empty;
    assign water_level  = r_level;

`ifdef SFIFO_ERR_FLAG_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_wr_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_rd_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Rejected requests are dropped silently when the error flags are not built.
`endif

endmodule
